mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_phase.sv | 28 ++
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the four-phase memory arbiter.
// Frame layout: two DMA phases followed by two CPU phases.
package mem_arbiter_pkg;

  localparam int FRAME_LEN = 4;

  localparam logic [1:0] PH_DMA0 = 2'd0;
  localparam logic [1:0] PH_DMA1 = 2'd1;
  localparam logic [1:0] PH_CPU0 = 2'd2;
  localparam logic [1:0] PH_CPU1 = 2'd3;
  localparam logic [1:0] PH_LAST = 2'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    RUN,
    HOLD_WAIT,
    HOLD
  } state_t;

endpackage

// File: rtl/mem_arbiter_phase.sv
// Frame phase counter and CPU clock-enable generation.
// One CPU step is granted in the last phase of every running frame.
module mem_arbiter_phase
  import mem_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_run,
  output logic [1:0] o_phase,
  output logic       o_cpu_ce
);

  logic [1:0] r_phase;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_phase <= PH_DMA0;
    end else if (r_phase == PH_LAST) begin
      r_phase <= PH_DMA0;
    end else begin
      r_phase <= r_phase + 2'd1;
    end
  end

  assign o_phase  = r_phase;
  assign o_cpu_ce = reset_n & i_run & (r_phase == PH_CPU1);

endmodule

// File: rtl/mem_arbiter.sv
// Time-slotted SRAM arbiter between CPU and video/DMA fetcher.
// Bus hold (RUN/HOLD_WAIT/HOLD) is built only with MEM_ARBITER_HOLD_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] cpu_address,
  input  logic        cpu_rd,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_out,
  output logic        cpu_ce,
  output logic [7:0]  cpu_in,
  input  logic        dma_req,
  input  logic [15:0] dma_address,
  output logic        dma_ack,
  output logic [7:0]  dma_data,
  input  logic        dma_hold,
  output logic        hlda,
  output logic [15:0] mem_address,
  input  logic [7:0]  mem_in,
  output logic [7:0]  mem_out,
  output logic        mem_we
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] w_phase;
  logic       w_hold;
  logic       w_start;
  logic       w_capture;
  logic       r_pend;
  logic       r_ack;
  logic [7:0] r_dma_data;
  logic       w_unused;

  assign w_unused = cpu_rd ^ dma_hold;
  assign w_hold   = (r_state == HOLD);

  mem_arbiter_phase u_phase (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_run    (~w_hold),
    .o_phase  (w_phase),
    .o_cpu_ce (cpu_ce)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Hold decisions are only taken at frame boundaries.
  always_comb begin
    w_state_nxt = r_state;
`ifdef MEM_ARBITER_HOLD_EN
    if (w_phase == PH_CPU1) begin
      unique case (r_state)
        RUN: begin
          if (dma_hold) w_state_nxt = HOLD_WAIT;
        end
        HOLD_WAIT: begin
          if (!dma_hold)    w_state_nxt = RUN;
          else if (!cpu_we) w_state_nxt = HOLD;
        end
        HOLD: begin
          if (!dma_hold) w_state_nxt = RUN;
        end
        default: w_state_nxt = RUN;
      endcase
    end
`else
    w_state_nxt = RUN;
`endif
  end

  // Reads launch on even phases; in HOLD both halves of the frame are DMA.
  assign w_start   = dma_req & ~w_phase[0]
                   & ((w_phase == PH_DMA0) | w_hold);
  assign w_capture = r_pend & w_phase[0];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_pend     <= 1'b0;
      r_ack      <= 1'b0;
      r_dma_data <= 8'h00;
    end else begin
      r_pend <= w_start;
      r_ack  <= w_capture;
      if (w_capture) r_dma_data <= mem_in;
    end
  end

  assign dma_ack  = r_ack & reset_n;
  assign dma_data = r_dma_data;
  assign hlda     = w_hold & reset_n;
  assign cpu_in   = mem_in;
  assign mem_out  = cpu_out;

  assign mem_address = (w_hold | ~w_phase[1]) ? dma_address
                                              : cpu_address;
  assign mem_we = reset_n & ~w_hold & cpu_we
                & (w_phase == PH_CPU0);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter with a one-cycle SRAM model.
// Hold sequences are compiled in with MEM_ARBITER_HOLD_EN.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_address;
  logic        cpu_rd;
  logic        cpu_we;
  logic [7:0]  cpu_out;
  logic        cpu_ce;
  logic [7:0]  cpu_in;
  logic        dma_req;
  logic [15:0] dma_address;
  logic        dma_ack;
  logic [7:0]  dma_data;
  logic        dma_hold;
  logic        hlda;
  logic [15:0] mem_address;
  logic [7:0]  mem_in;
  logic [7:0]  mem_out;
  logic        mem_we;

  int checks = 0;
  int errors = 0;
  int tag = 0;

  logic [7:0] mem [0:65535];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_we) mem[mem_address] <= mem_out;
    mem_in <= mem[mem_address];
  end

  mem_arbiter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cpu_address (cpu_address),
    .cpu_rd      (cpu_rd),
    .cpu_we      (cpu_we),
    .cpu_out     (cpu_out),
    .cpu_ce      (cpu_ce),
    .cpu_in      (cpu_in),
    .dma_req     (dma_req),
    .dma_address (dma_address),
    .dma_ack     (dma_ack),
    .dma_data    (dma_data),
    .dma_hold    (dma_hold),
    .hlda        (hlda),
    .mem_address (mem_address),
    .mem_in      (mem_in),
    .mem_out     (mem_out),
    .mem_we      (mem_we)
  );

  typedef struct {
    logic        dreq;
    logic        dhold;
    logic        we;
    logic [15:0] caddr;
    logic [7:0]  cout;
    logic [15:0] daddr;
    logic        ce;
    logic        mwe;
    logic        ack;
    logic        hlda;
    logic [15:0] maddr;
    logic [7:0]  ddata;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(
    logic dreq, logic dhold, logic we,
    logic [15:0] caddr, logic [7:0] cout,
    logic [15:0] daddr,
    logic ce, logic mwe, logic ack, logic hl,
    logic [15:0] maddr, logic [7:0] ddata);
    vec_t v;
    v.dreq = dreq; v.dhold = dhold; v.we = we;
    v.caddr = caddr; v.cout = cout; v.daddr = daddr;
    v.ce = ce; v.mwe = mwe; v.ack = ack; v.hlda = hl;
    v.maddr = maddr; v.ddata = ddata;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %h, expected %h",
               nm, tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    dma_req = 1'b0; dma_hold = 1'b0;
    cpu_we = 1'b0; cpu_rd = 1'b0;
    cpu_address = 16'h0000; cpu_out = 8'h00;
    dma_address = 16'h0000;
  endtask

  // Leaves time at a falling edge with cycle 1 (phase 0) starting.
  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clock);
    #1;
    chk("rst_cpu_ce", {15'b0, cpu_ce}, 16'h0);
    chk("rst_dma_ack", {15'b0, dma_ack}, 16'h0);
    chk("rst_mem_we", {15'b0, mem_we}, 16'h0);
    chk("rst_hlda", {15'b0, hlda}, 16'h0);
    chk("rst_dma_data", {8'b0, dma_data}, 16'h0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic step(input vec_t v);
    dma_req = v.dreq; dma_hold = v.dhold;
    cpu_we = v.we; cpu_rd = ~v.we;
    cpu_address = v.caddr; cpu_out = v.cout;
    dma_address = v.daddr;
    #1;
    chk("cpu_ce", {15'b0, cpu_ce}, {15'b0, v.ce});
    chk("mem_we", {15'b0, mem_we}, {15'b0, v.mwe});
    chk("dma_ack", {15'b0, dma_ack}, {15'b0, v.ack});
    chk("hlda", {15'b0, hlda}, {15'b0, v.hlda});
    chk("mem_address", mem_address, v.maddr);
    chk("dma_data", {8'b0, dma_data}, {8'b0, v.ddata});
    if (v.mwe) chk("mem_out", {8'b0, mem_out}, {8'b0, v.cout});
    @(negedge clock);
  endtask

  // Expects cpu_ce exactly on clocks 4, 8, ... after release.
  task automatic cadence(input int n, input string nm);
    for (int k = 1; k <= n; k++) begin
      tag = k;
      #1;
      chk(nm, {15'b0, cpu_ce}, {15'b0, (k % 4) == 0});
      chk("idle_mem_we", {15'b0, mem_we}, 16'h0);
      chk("idle_dma_ack", {15'b0, dma_ack}, 16'h0);
      @(negedge clock);
    end
  endtask

  localparam logic [15:0] C = 16'h7000;
  localparam logic [15:0] D = 16'h76D0;
  localparam logic [15:0] E = 16'h1234;
  localparam logic [15:0] F = 16'h7001;

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    mem[D] = 8'h11;
    mem[E] = 8'h22;
    mem[C] = 8'h00;
    mem[F] = 8'h00;

    do_reset();
    cadence(12, "idle_cpu_ce");

    tab.delete();
    // idle frame
    tab.push_back(mk(0,0,0,C,8'h5A,D, 0,0,0,0,D,8'h00));
    tab.push_back(mk(0,0,0,C,8'h5A,D, 0,0,0,0,D,8'h00));
    tab.push_back(mk(0,0,0,C,8'h5A,D, 0,0,0,0,C,8'h00));
    tab.push_back(mk(0,0,0,C,8'h5A,D, 1,0,0,0,C,8'h00));
    // CPU write 0x5A to 0x7000
    tab.push_back(mk(0,0,1,C,8'h5A,D, 0,0,0,0,D,8'h00));
    tab.push_back(mk(0,0,1,C,8'h5A,D, 0,0,0,0,D,8'h00));
    tab.push_back(mk(0,0,1,C,8'h5A,D, 0,1,0,0,C,8'h00));
    tab.push_back(mk(0,0,1,C,8'h5A,D, 1,0,0,0,C,8'h00));
    // DMA read of 0x76D0
    tab.push_back(mk(1,0,0,C,8'h5A,D, 0,0,0,0,D,8'h00));
    tab.push_back(mk(1,0,0,C,8'h5A,D, 0,0,0,0,D,8'h00));
    tab.push_back(mk(1,0,0,C,8'h5A,D, 0,0,1,0,C,8'h11));
    tab.push_back(mk(1,0,0,C,8'h5A,D, 1,0,0,0,C,8'h11));
    // DMA reads back the CPU-written byte
    tab.push_back(mk(1,0,0,C,8'h5A,C, 0,0,0,0,C,8'h11));
    tab.push_back(mk(1,0,0,C,8'h5A,C, 0,0,0,0,C,8'h11));
    tab.push_back(mk(1,0,0,C,8'h5A,C, 0,0,1,0,C,8'h5A));
    tab.push_back(mk(1,0,0,C,8'h5A,C, 1,0,0,0,C,8'h5A));
    // request rising in phase 1 waits a frame
    tab.push_back(mk(0,0,0,C,8'h5A,E, 0,0,0,0,E,8'h5A));
    tab.push_back(mk(1,0,0,C,8'h5A,E, 0,0,0,0,E,8'h5A));
    tab.push_back(mk(1,0,0,C,8'h5A,E, 0,0,0,0,C,8'h5A));
    tab.push_back(mk(1,0,0,C,8'h5A,E, 1,0,0,0,C,8'h5A));
    // DMA read and CPU write in the same frame
    tab.push_back(mk(1,0,1,F,8'hA5,E, 0,0,0,0,E,8'h5A));
    tab.push_back(mk(0,0,1,F,8'hA5,E, 0,0,0,0,E,8'h5A));
    tab.push_back(mk(0,0,1,F,8'hA5,E, 0,1,1,0,F,8'h22));
    tab.push_back(mk(0,0,1,F,8'hA5,E, 1,0,0,0,F,8'h22));

    do_reset();
    foreach (tab[i]) begin
      tag = 100 + i;
      step(tab[i]);
    end
    idle_inputs();
    tag = 200;
    chk("sram_7000", {8'b0, mem[C]}, 16'h005A);
    chk("sram_7001", {8'b0, mem[F]}, 16'h00A5);

    // reset while an ack is on the bus
    do_reset();
    dma_req = 1'b1;
    dma_address = D;
    repeat (2) @(negedge clock);
    #1;
    tag = 300;
    chk("pre_rst_ack", {15'b0, dma_ack}, 16'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ack", {15'b0, dma_ack}, 16'h0);
    chk("mid_rst_ce", {15'b0, cpu_ce}, 16'h0);
    @(negedge clock);
    dma_req = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    cadence(8, "rst_dma_cpu_ce");

`ifdef MEM_ARBITER_HOLD_EN
    tab.delete();
    // hold requested while CPU writes: grant deferred
    for (int f = 0; f < 2; f++) begin
      tab.push_back(mk(0,1,1,C,8'h5A,D, 0,0,0,0,D,8'h00));
      tab.push_back(mk(0,1,1,C,8'h5A,D, 0,0,0,0,D,8'h00));
      tab.push_back(mk(0,1,1,C,8'h5A,D, 0,1,0,0,C,8'h00));
      tab.push_back(mk(0,1,1,C,8'h5A,D, 1,0,0,0,C,8'h00));
    end
    tab.push_back(mk(0,1,0,C,8'h5A,D, 0,0,0,0,D,8'h00));
    tab.push_back(mk(0,1,0,C,8'h5A,D, 0,0,0,0,D,8'h00));
    tab.push_back(mk(0,1,0,C,8'h5A,D, 0,0,0,0,C,8'h00));
    tab.push_back(mk(0,1,0,C,8'h5A,D, 1,0,0,0,C,8'h00));
    // HOLD: two acks per frame, CPU frozen
    tab.push_back(mk(1,1,1,C,8'h5A,D, 0,0,0,1,D,8'h00));
    tab.push_back(mk(1,1,1,C,8'h5A,D, 0,0,0,1,D,8'h00));
    tab.push_back(mk(1,1,1,C,8'h5A,D, 0,0,1,1,D,8'h11));
    tab.push_back(mk(1,1,1,C,8'h5A,D, 0,0,0,1,D,8'h11));
    tab.push_back(mk(1,0,0,C,8'h5A,D, 0,0,1,1,D,8'h11));
    tab.push_back(mk(1,0,0,C,8'h5A,D, 0,0,0,1,D,8'h11));
    tab.push_back(mk(1,0,0,C,8'h5A,D, 0,0,1,1,D,8'h11));
    tab.push_back(mk(1,0,0,C,8'h5A,D, 0,0,0,1,D,8'h11));
    // back in RUN
    tab.push_back(mk(1,0,0,C,8'h5A,D, 0,0,1,0,D,8'h11));
    tab.push_back(mk(1,0,0,C,8'h5A,D, 0,0,0,0,D,8'h11));
    tab.push_back(mk(1,0,0,C,8'h5A,D, 0,0,1,0,C,8'h11));
    tab.push_back(mk(1,0,0,C,8'h5A,D, 1,0,0,0,C,8'h11));

    do_reset();
    foreach (tab[i]) begin
      tag = 400 + i;
      step(tab[i]);
    end

    // reset while held with a DMA ack on the bus
    do_reset();
    dma_hold = 1'b1;
    dma_req = 1'b1;
    dma_address = D;
    repeat (8) @(negedge clock);
    #1;
    tag = 500;
    chk("held_hlda", {15'b0, hlda}, 16'h1);
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("held_ack", {15'b0, dma_ack}, 16'h1);
    reset_n = 1'b0;
    #1;
    chk("hold_rst_hlda", {15'b0, hlda}, 16'h0);
    chk("hold_rst_ack", {15'b0, dma_ack}, 16'h0);
    @(negedge clock);
    dma_hold = 1'b0;
    dma_req = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    cadence(8, "rst_hold_cpu_ce");
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
